// File: rtl/sm_mult_arbiter.sv
// rtl/sm_mult_arbiter.sv - round-robin scheduler sharing one mult scalar-multiplication unit
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready [N]      per-requester job handshake (ready is one-hot)
//   req_l/req_x/req_y [N*256]    packed job operands, requester i at [256i +: 256]
//   rsp_valid/rsp_ready          tagged response handshake
//   rsp_id/rsp_x/rsp_y/rsp_err   owner, result point, reject/timeout flag
//   busy                         high while a job is in flight or awaiting response
//   mult_rst_b/mult_en           unit reset (active low) and start strobe
//   mult_l/mult_x0/mult_y0       registered operands to the unit
//   mult_x1/mult_y1/mult_sign    unit result and sticky done flag
module sm_mult_arbiter #(
    parameter int N       = 2,
    parameter int CLR_CYC = 2,
    parameter int TIMEOUT = 1 << 20,
    parameter int IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*256-1:0] req_l,
    input  logic [N*256-1:0] req_x,
    input  logic [N*256-1:0] req_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [255:0]     rsp_x,
    output logic [255:0]     rsp_y,
    output logic             rsp_err,
    output logic             busy,
    output logic             mult_rst_b,
    output logic             mult_en,
    output logic [255:0]     mult_l,
    output logic [255:0]     mult_x0,
    output logic [255:0]     mult_y0,
    input  logic [255:0]     mult_x1,
    input  logic [255:0]     mult_y1,
    input  logic             mult_sign
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_START,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [31:0]    timer;
    logic [31:0]    clr_cnt;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [255:0]   gnt_l;
    logic [255:0]   gnt_x;
    logic [255:0]   gnt_y;
    logic [2*N-1:0] rot_valid;

    // Rotate the doubled request vector so bit k corresponds to requester
    // (ptr + k) mod N; the first set bit is the round-robin winner.
    always_comb begin
        int sum;
        sum       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rot_valid = {req_valid, req_valid} >> ptr;
        for (int k = 0; k < N; k++) begin
            if (!gnt_found && rot_valid[k]) begin
                gnt_found = 1'b1;
                sum       = int'(ptr) + k;
                if (sum >= N) begin
                    sum = sum - N;
                end
                gnt_idx = IDW'(sum);
            end
        end
    end

    always_comb begin
        gnt_l = '0;
        gnt_x = '0;
        gnt_y = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == IDW'(i)) begin
                gnt_l = req_l[i*256 +: 256];
                gnt_x = req_x[i*256 +: 256];
                gnt_y = req_y[i*256 +: 256];
            end
        end
    end

    // Accept is combinational so the grant and operand capture share one cycle;
    // suppressed during reset so no job is taken that the reset would drop.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            req_ready[i] = !rst && (state == ST_IDLE) && gnt_found && (gnt_idx == IDW'(i));
        end
    end

    assign rsp_valid  = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);
    // The unit loads its operand registers while in reset, and reset also
    // clears a stale done flag or a unit abandoned by a timeout.
    assign mult_rst_b = !(rst || (state == ST_CLR));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            timer   <= '0;
            clr_cnt <= '0;
            rsp_id  <= '0;
            rsp_x   <= '0;
            rsp_y   <= '0;
            rsp_err <= 1'b0;
            mult_en <= 1'b0;
            mult_l  <= '0;
            mult_x0 <= '0;
            mult_y0 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_found) begin
                        rsp_id  <= gnt_idx;
                        mult_l  <= gnt_l;
                        mult_x0 <= gnt_x;
                        mult_y0 <= gnt_y;
                        ptr     <= (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
                        if (gnt_l == '0) begin
                            // A zero scalar is rejected without touching the unit.
                            rsp_err <= 1'b1;
                            rsp_x   <= '0;
                            rsp_y   <= '0;
                            state   <= ST_RESP;
                        end else begin
                            clr_cnt <= '0;
                            state   <= ST_CLR;
                        end
                    end
                end
                ST_CLR: begin
                    if (clr_cnt == 32'(CLR_CYC - 1)) begin
                        mult_en <= 1'b1;
                        state   <= ST_START;
                    end else begin
                        clr_cnt <= clr_cnt + 32'd1;
                    end
                end
                ST_START: begin
                    mult_en <= 1'b0;
                    timer   <= '0;
                    state   <= ST_BUSY;
                end
                ST_BUSY: begin
                    timer <= timer + 32'd1;
                    // Completion wins over a timeout landing in the same cycle.
                    if (mult_sign) begin
                        rsp_x   <= mult_x1;
                        rsp_y   <= mult_y1;
                        rsp_err <= 1'b0;
                        state   <= ST_RESP;
                    end else if (timer == 32'(TIMEOUT - 1)) begin
                        rsp_x   <= '0;
                        rsp_y   <= '0;
                        rsp_err <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_mult_arbiter.sv
// tb/tb_sm_mult_arbiter.sv - directed self-checking bench for sm_mult_arbiter
module tb_sm_mult_arbiter;

    localparam logic [255:0] PX = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0001;
    localparam logic [255:0] PY = 256'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100_f0e0_d0c0_b0a0_9080_7060_5040_3020_1000;
    localparam logic [255:0] QX = 256'hdead_beef_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_cafe_f00d;
    localparam logic [255:0] QY = 256'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_00f0;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [511:0]   req_l, req_x, req_y;
    logic           rsp_valid, rsp_ready;
    logic [0:0]     rsp_id;
    logic [255:0]   rsp_x, rsp_y;
    logic           rsp_err, busy;
    logic           mult_rst_b, mult_en;
    logic [255:0]   mult_l, mult_x0, mult_y0;
    logic [255:0]   mult_x1, mult_y1;
    logic           mult_sign;

    int total = 0;
    int bad   = 0;
    int m_delay;
    bit m_hang;
    int m_cnt;
    bit m_run;

    sm_mult_arbiter #(.N(2), .CLR_CYC(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_l(req_l), .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err),
        .busy(busy),
        .mult_rst_b(mult_rst_b), .mult_en(mult_en),
        .mult_l(mult_l), .mult_x0(mult_x0), .mult_y0(mult_y0),
        .mult_x1(mult_x1), .mult_y1(mult_y1), .mult_sign(mult_sign)
    );

    always #5 clk = ~clk;

    // Unit model: result is x0^l, y0+l; done flag rises m_delay cycles after
    // the start cycle and stays high until the unit is reset.
    always @(posedge clk) begin
        if (!mult_rst_b) begin
            mult_sign <= 1'b0;
            m_run     <= 1'b0;
            m_cnt     <= 0;
        end else if (mult_en) begin
            m_run   <= 1'b1;
            m_cnt   <= m_delay - 2;
            mult_x1 <= mult_x0 ^ mult_l;
            mult_y1 <= mult_y0 + mult_l;
        end else if (m_run && !m_hang) begin
            if (m_cnt == 0) begin
                mult_sign <= 1'b1;
                m_run     <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [255:0] l, input logic [255:0] x, input logic [255:0] y);
        req_l[i*256 +: 256] = l;
        req_x[i*256 +: 256] = x;
        req_y[i*256 +: 256] = y;
        req_valid[i] = 1'b1;
    endtask

    // Waits for an accept, checks which requester got it, then passes the
    // handshake edge, drops that valid and scrambles its operands.
    task automatic wait_grant(input logic [1:0] exp, input string tag);
        int n;
        logic [1:0] g;
        n = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        g = req_ready;
        check({tag, "_grant"}, g, exp);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
                req_valid[i] = 1'b0;
                req_l[i*256 +: 256] = '1;
                req_x[i*256 +: 256] = '1;
                req_y[i*256 +: 256] = '1;
            end
        end
    endtask

    // Cycle index (handshake cycle = 0) of the first cycle with rsp_valid,
    // plus counts of unit-reset and start cycles seen on the way.
    task automatic wait_rsp(output int lat, output int rlow, output int ens);
        lat  = 1;
        rlow = mult_rst_b ? 0 : 1;
        ens  = mult_en ? 1 : 0;
        while (!rsp_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            rlow += mult_rst_b ? 0 : 1;
            ens  += mult_en ? 1 : 0;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat, rlow, ens, nrsp;
        rst = 1'b1; req_valid = 2'b11; req_l = '1; req_x = '0; req_y = '0;
        rsp_ready = 1'b0; m_delay = 40; m_hang = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mult_rst_b", mult_rst_b, 1'b0);
        check("rst_mult_en", mult_en, 1'b0);
        check("rst_mult_l", mult_l, 256'd0);
        check("rst_mult_x0", mult_x0, 256'd0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_x", rsp_x, 256'd0);
        check("rst_rsp_err", rsp_err, 1'b0);
        req_valid = 2'b00;
        rst = 1'b0;
        #1;
        check("post_rst_mult_rst_b", mult_rst_b, 1'b1);

        // Single job: l=3, done 40 cycles after start -> response in cycle 44
        set_req(0, 256'd3, PX, PY);
        m_delay = 40;
        wait_grant(2'b01, "single");
        wait_rsp(lat, rlow, ens);
        check("single_lat", lat, 44);
        check("single_rst_low", rlow, 2);
        check("single_en_pulses", ens, 1);
        check("single_id", rsp_id, 1'b0);
        check("single_x", rsp_x, PX ^ 256'd3);
        check("single_y", rsp_y, PY + 256'd3);
        check("single_err", rsp_err, 1'b0);
        take_rsp();
        check("single_idle", busy, 1'b0);

        // Zero scalar from requester 1 (ptr is now 1)
        set_req(1, 256'd0, PX, PY);
        wait_grant(2'b10, "zero");
        wait_rsp(lat, rlow, ens);
        check("zero_lat", lat, 1);
        check("zero_rst_low", rlow, 0);
        check("zero_en", ens, 0);
        check("zero_id", rsp_id, 1'b1);
        check("zero_err", rsp_err, 1'b1);
        check("zero_x", rsp_x, 256'd0);
        check("zero_y", rsp_y, 256'd0);
        take_rsp();

        // Contention at ptr=0: 0 then 1, then 0 again after wrap
        m_delay = 5;
        set_req(0, 256'd11, QX, QY);
        set_req(1, 256'd13, PX, PY);
        wait_grant(2'b01, "cont_a");
        wait_rsp(lat, rlow, ens);
        check("cont_a_lat", lat, 9);
        check("cont_a_id", rsp_id, 1'b0);
        check("cont_a_x", rsp_x, QX ^ 256'd11);
        take_rsp();
        wait_grant(2'b10, "cont_b");
        wait_rsp(lat, rlow, ens);
        check("cont_b_id", rsp_id, 1'b1);
        check("cont_b_y", rsp_y, PY + 256'd13);
        take_rsp();
        set_req(0, 256'd17, PX, QY);
        set_req(1, 256'd19, QX, PY);
        wait_grant(2'b01, "cont_c");
        wait_rsp(lat, rlow, ens);
        check("cont_c_id", rsp_id, 1'b0);
        check("cont_c_x", rsp_x, PX ^ 256'd17);
        take_rsp();
        wait_grant(2'b10, "cont_d");
        wait_rsp(lat, rlow, ens);
        check("cont_d_x", rsp_x, QX ^ 256'd19);
        take_rsp();

        // Timeout: BUSY starts in cycle 4, so response in cycle 4+64
        m_hang = 1'b1;
        set_req(0, 256'd21, PX, PY);
        wait_grant(2'b01, "tmo");
        wait_rsp(lat, rlow, ens);
        check("tmo_lat", lat, 68);
        check("tmo_err", rsp_err, 1'b1);
        check("tmo_x", rsp_x, 256'd0);
        check("tmo_y", rsp_y, 256'd0);
        check("tmo_id", rsp_id, 1'b0);
        take_rsp();

        // Next job: done flag lands on the last timer cycle, completion wins
        m_hang = 1'b0;
        m_delay = 64;
        set_req(1, 256'd23, QX, QY);
        wait_grant(2'b10, "prio");
        wait_rsp(lat, rlow, ens);
        check("prio_rst_low", rlow, 2);
        check("prio_lat", lat, 68);
        check("prio_err", rsp_err, 1'b0);
        check("prio_x", rsp_x, QX ^ 256'd23);
        check("prio_y", rsp_y, QY + 256'd23);
        take_rsp();

        // Backpressure: response held 10 cycles while requester 1 waits
        m_delay = 3;
        set_req(0, 256'd7, PX, PY);
        wait_grant(2'b01, "bp");
        wait_rsp(lat, rlow, ens);
        check("bp_lat", lat, 7);
        set_req(1, 256'd0, QX, QY);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_req_ready", req_ready, 2'b00);
            check("bp_x", rsp_x, PX ^ 256'd7);
        end
        take_rsp();
        check("bp_next_grant", req_ready, 2'b10);
        wait_grant(2'b10, "bp_next");
        wait_rsp(lat, rlow, ens);
        check("bp_next_err", rsp_err, 1'b1);
        take_rsp();

        // Reset while BUSY
        m_delay = 40;
        set_req(0, 256'd9, PX, PY);
        wait_grant(2'b01, "rb");
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("rb_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rb_mult_rst_b", mult_rst_b, 1'b0);
        @(posedge clk);
        #1;
        check("rb_busy", busy, 1'b0);
        check("rb_rsp_valid", rsp_valid, 1'b0);
        check("rb_mult_en", mult_en, 1'b0);
        check("rb_mult_l", mult_l, 256'd0);
        check("rb_rsp_err", rsp_err, 1'b0);
        rst = 1'b0;
        nrsp = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (rsp_valid) nrsp++;
        end
        check("rb_no_rsp", nrsp, 0);
        m_delay = 5;
        set_req(0, 256'd25, QX, PY);
        set_req(1, 256'd27, PX, QY);
        wait_grant(2'b01, "rb_ptr");
        wait_rsp(lat, rlow, ens);
        check("rb_job_x", rsp_x, QX ^ 256'd25);
        take_rsp();
        wait_grant(2'b10, "rb_drain");
        wait_rsp(lat, rlow, ens);
        check("rb_drain_y", rsp_y, QY + 256'd27);
        take_rsp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
